// File: rtl/imem_prog_loader.sv
// Instruction memory program loader.
// Streams words from a valid/ready source into big-endian byte writes while stalling the core.
module imem_prog_loader #(
  parameter int ADDR_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [ADDR_BUS_WIDTH-1:0] base_addr,
  input  logic [COUNT_WIDTH-1:0]    word_count,
  input  logic                      s_valid,
  input  logic [DATA_BUS_WIDTH-1:0] s_data,
  output logic                      s_ready,
  output logic                      mem_we,
  output logic [ADDR_BUS_WIDTH-1:0] mem_addr,
  output logic [7:0]                mem_wdata,
  output logic                      busy,
  output logic                      cpu_stall,
  output logic                      done,
  output logic                      err
);

  localparam int BYTES = DATA_BUS_WIDTH / 8;
  localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_WORD,
    WRITE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [ADDR_BUS_WIDTH-1:0] ptr;
  logic [COUNT_WIDTH-1:0]    remaining;
  logic [IDXW-1:0]           byte_idx;
  logic [DATA_BUS_WIDTH-1:0] shreg;
  logic                      err_q;
  logic                      misaligned;
  logic                      last_byte;
  logic                      start_ok;

  assign misaligned = |(base_addr & ADDR_BUS_WIDTH'(BYTES - 1));
  assign last_byte  = (byte_idx == IDXW'(BYTES - 1));
  assign start_ok   = (state == IDLE) && start && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nx = (word_count == '0) ? DONE : WAIT_WORD;
        end
      end
      WAIT_WORD: begin
        if (s_valid) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        if (last_byte) begin
          state_nx = (remaining == COUNT_WIDTH'(1)) ? DONE : WAIT_WORD;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bytes leave the top of the shift register, so MSB goes to the lowest address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (state == IDLE) && start && misaligned;
      if (start_ok && (word_count != '0)) begin
        ptr       <= base_addr;
        remaining <= word_count;
      end
      if ((state == WAIT_WORD) && s_valid) begin
        shreg    <= s_data;
        byte_idx <= '0;
      end
      if (state == WRITE) begin
        ptr      <= ptr + ADDR_BUS_WIDTH'(1);
        shreg    <= shreg << 8;
        byte_idx <= byte_idx + IDXW'(1);
        if (last_byte) begin
          remaining <= remaining - COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign s_ready   = (state == WAIT_WORD);
  assign mem_we    = (state == WRITE);
  assign mem_addr  = ptr;
  assign mem_wdata = shreg[DATA_BUS_WIDTH-1 -: 8];
  assign busy      = (state == WAIT_WORD) || (state == WRITE);
  assign cpu_stall = busy;
  assign done      = (state == DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_imem_prog_loader.sv
// Scoreboard bench for imem_prog_loader.
// Stimulus pushes expected byte writes / done / err events; a negedge monitor pops and compares.
module tb_imem_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        cpu_stall;
  logic        done;
  logic        err;

  imem_prog_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .cpu_stall (cpu_stall),
    .done      (done),
    .err       (err)
  );

  localparam logic [1:0] K_WR   = 2'd0;
  localparam logic [1:0] K_DONE = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void push_ev(input logic [1:0] k,
                                  input logic [15:0] a,
                                  input logic [7:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endfunction

  function automatic void check_ev(input logic [1:0] k,
                                   input logic [15:0] a,
                                   input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event kind=%0d addr=%h data=%h expected none",
               k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.addr != a || e.data != d) begin
        errors++;
        $display("FAIL event got kind=%0d addr=%h data=%h expected kind=%0d addr=%h data=%h",
                 k, a, d, e.kind, e.addr, e.data);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        check_ev(K_WR, mem_addr, mem_wdata);
        checks++;
        if (s_ready || !busy || !cpu_stall) begin
          errors++;
          $display("FAIL write_flags s_ready=%b busy=%b stall=%b expected 0 1 1",
                   s_ready, busy, cpu_stall);
        end
      end
      if (done) begin
        check_ev(K_DONE, 16'h0, 8'h0);
        checks++;
        if (busy || cpu_stall) begin
          errors++;
          $display("FAIL done_busy busy=%b stall=%b expected 0 0", busy, cpu_stall);
        end
      end
      if (err) begin
        check_ev(K_ERR, 16'h0, 8'h0);
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL err_busy busy=%b expected 0", busy);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {s_ready, mem_we, mem_addr, mem_wdata, busy, cpu_stall, done, err},
        64'h0);
  endtask

  task automatic pulse_start(input logic [15:0] base, input logic [15:0] n);
    @(posedge clk);
    #1;
    base_addr  = base;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    while (t < 100) begin
      @(negedge clk);
      if (s_ready) break;
      t++;
    end
    s_valid = 1'b0;
    chk("s_ready_wait", {63'h0, s_ready}, 64'h1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk(name, 64'(exp_q.size()), 64'h0);
    repeat (3) @(negedge clk);
    s_valid = 1'b0;
  endtask

  // After each accepted word the source keeps s_valid high with junk data
  // through the write cycles; that junk must never be written.
  task automatic load(input string name, input logic [15:0] base, input int n,
                      input logic [31:0] w[4], input int gap);
    logic [15:0] a;
    a = base;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        push_ev(K_WR, a, w[i][31-8*b -: 8]);
        a = a + 16'h1;
      end
    end
    push_ev(K_DONE, 16'h0, 8'h0);
    pulse_start(base, 16'(n));
    @(negedge clk);
    chk({name, "_busy_after_start"}, {62'h0, busy, cpu_stall}, 64'h3);
    for (int i = 0; i < n; i++) begin
      wait_ready();
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        chk({name, "_stall_hold"}, {62'h0, busy, s_ready}, 64'h3);
      end
      s_valid = 1'b1;
      s_data  = w[i];
      @(posedge clk);
      #1;
      s_data = 32'hDEADBEEF;
    end
    drain(name);
  endtask

  logic [31:0] words[4];

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    #3;
    chk_zero("reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle_outputs");

    words = '{32'hFFC4A303, 32'h0, 32'h0, 32'h0};
    load("single", 16'h0004, 1, words, 0);

    words = '{32'h0064A423, 32'h0062E233, 32'h00420C63, 32'h0};
    load("multi_gap", 16'h0008, 3, words, 2);

    push_ev(K_ERR, 16'h0, 8'h0);
    pulse_start(16'h0006, 16'd1);
    @(negedge clk);
    chk("misaligned_busy", {63'h0, busy}, 64'h0);
    drain("misaligned");

    push_ev(K_DONE, 16'h0, 8'h0);
    pulse_start(16'h0000, 16'd0);
    chk("empty_busy", {63'h0, busy}, 64'h0);
    drain("empty");

    words = '{32'h11223344, 32'h55667788, 32'h0, 32'h0};
    load("wrap", 16'hFFFC, 2, words, 0);

    // Reset after the second byte of the first word: only two bytes land.
    push_ev(K_WR, 16'h0040, 8'hA1);
    push_ev(K_WR, 16'h0041, 8'hB2);
    pulse_start(16'h0040, 16'd2);
    wait_ready();
    s_valid = 1'b1;
    s_data  = 32'hA1B2C3D4;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (mem_we) break;
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset_outputs");
    chk("reset_q_empty", 64'(exp_q.size()), 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("post_reset_idle");

    words = '{32'h12345678, 32'h0, 32'h0, 32'h0};
    load("after_reset", 16'h0020, 1, words, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
